// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding and baud divider helper shared by the UART receiver and transmitter.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;

    localparam int OVERSAMPLE_DEFAULT = 16;

    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int d;
        d = clk_freq / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: free-running divider producing one tick per oversample period.
import uart_pkg::*;

module baud_tick_gen #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_tick
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign o_tick = (cnt == W'(DIV - 1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            cnt <= '0;
        else
            cnt <= o_tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: oversampling 8N1 UART receiver with byte strobe and frame-error pulse.
// Defining UART_RX_PARITY_EN adds an even-parity bit and the o_parity_error output.
import uart_pkg::*;

module uart_rx_frontend #(
    parameter int BYTE       = 8,
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_rx,
    output logic [BYTE-1:0] o_data,
    output logic            o_rx_done,
    output logic            o_frame_error,
`ifdef UART_RX_PARITY_EN
    output logic            o_parity_error,
`endif
    output logic            o_busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(BYTE + 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_LAST = NW'(BYTE - 1);
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] AFTER_DATA = ST_PARITY;
`else
    localparam logic [2:0] AFTER_DATA = ST_STOP;
`endif

    logic [1:0]      sync;
    logic            rx_s;
    logic            tick;
    logic            sample;
    logic            stop_sample;
    logic            parity_bad;
    logic [2:0]      state, state_n;
    logic [SW-1:0]   s_cnt, s_cnt_n;
    logic [NW-1:0]   n_cnt, n_cnt_n;
    logic [BYTE-1:0] sh, sh_n;
    logic [BYTE-1:0] data_n;
    logic            done_n, ferr_n, busy_n;
`ifdef UART_RX_PARITY_EN
    logic            par, par_n;
    logic            perr_n;
`endif

    baud_tick_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .o_tick (tick)
    );

    assign rx_s        = sync[1];
    assign sample      = tick && (s_cnt == S_END);
    assign stop_sample = (state == ST_STOP) && sample;
`ifdef UART_RX_PARITY_EN
    assign parity_bad  = ^{sh, par};
`else
    assign parity_bad  = 1'b0;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sync          <= 2'b11;
            state         <= ST_IDLE;
            s_cnt         <= '0;
            n_cnt         <= '0;
            sh            <= '0;
            o_data        <= '0;
            o_rx_done     <= 1'b0;
            o_frame_error <= 1'b0;
            o_busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par            <= 1'b0;
            o_parity_error <= 1'b0;
`endif
        end else begin
            sync          <= {sync[0], i_rx};
            state         <= state_n;
            s_cnt         <= s_cnt_n;
            n_cnt         <= n_cnt_n;
            sh            <= sh_n;
            o_data        <= data_n;
            o_rx_done     <= done_n;
            o_frame_error <= ferr_n;
            o_busy        <= busy_n;
`ifdef UART_RX_PARITY_EN
            par            <= par_n;
            o_parity_error <= perr_n;
`endif
        end
    end

    // Counters move only on ticks; every other cycle holds state.
    always_comb begin
        state_n = state;
        s_cnt_n = s_cnt;
        n_cnt_n = n_cnt;
        sh_n    = sh;
`ifdef UART_RX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_n = ST_START;
                    s_cnt_n = '0;
                end
            end
            ST_START: begin
                n_cnt_n = '0;
                if (tick) begin
                    s_cnt_n = (s_cnt == S_MID) ? '0 : s_cnt + 1'b1;
                    if (s_cnt == S_MID)
                        state_n = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    s_cnt_n = sample ? '0 : s_cnt + 1'b1;
                    if (sample) begin
                        sh_n    = {rx_s, sh[BYTE-1:1]};
                        n_cnt_n = n_cnt + 1'b1;
                        state_n = (n_cnt == N_LAST) ? AFTER_DATA : ST_DATA;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    s_cnt_n = sample ? '0 : s_cnt + 1'b1;
                    if (sample) begin
                        par_n   = rx_s;
                        state_n = ST_STOP;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    s_cnt_n = sample ? '0 : s_cnt + 1'b1;
                    if (sample)
                        state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        done_n = stop_sample && rx_s && !parity_bad;
        ferr_n = stop_sample && !rx_s;
        data_n = done_n ? sh : o_data;
        busy_n = (state_n != ST_IDLE);
`ifdef UART_RX_PARITY_EN
        perr_n = stop_sample && parity_bad;
`endif
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: scoreboard bench driving serial frames and checking received bytes, errors and timing.
module tb_uart_rx_frontend;

    localparam int CLK_FREQ = 50000000;
    localparam int BAUD     = 312500;
    localparam int BIT      = 160;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 1520 + BIT;
`else
    localparam int LAT = 1520;
`endif

    typedef struct {
        logic [7:0] d;
        int         t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       done, ferr, busy;
`ifdef UART_RX_PARITY_EN
    logic       perr;
`endif

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   ferr_cnt = 0;
    int   perr_cnt = 0;
    int   last_done_cyc = 0;
    int   prev_done_cyc = 0;
    logic prev_pulse = 1'b0;
    exp_t sb[$];
    exp_t e;

    uart_rx_frontend #(
        .BYTE      (8),
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(16)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_rx         (rx),
        .o_data       (data),
        .o_rx_done    (done),
        .o_frame_error(ferr),
`ifdef UART_RX_PARITY_EN
        .o_parity_error(perr),
`endif
        .o_busy       (busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done || ferr) begin
                check("pulse_exclusive", done && ferr, 0);
                check("pulse_not_adjacent", prev_pulse, 0);
            end
            prev_pulse = done || ferr;
            if (done) begin
                done_cnt++;
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rx_data", data, e.d);
                    check("latency_in_window", (cyc - e.t >= LAT - 10) && (cyc - e.t <= LAT + 10), 1);
                end
            end
            if (ferr) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
            if (perr) perr_cnt++;
`endif
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len, input logic par_flip);
        if (stop && !par_flip) sb.push_back('{d, cyc});
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(posedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        repeat (BIT) @(posedge clk);
`endif
        rx = stop;
        repeat (stop_len) @(posedge clk);
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0] partial;
        #50;
        check("reset_data", data, 0);
        check("reset_done", done, 0);
        check("reset_ferr", ferr, 0);
        check("reset_busy", busy, 0);
        #50;
        rst = 1'b0;
        @(posedge clk);
        repeat (10 * BIT) @(posedge clk);
        check("idle_no_done", done_cnt, 0);
        check("idle_no_ferr", ferr_cnt, 0);
        check("idle_busy", busy, 0);

        send_frame(8'h04, 1'b1, BIT, 1'b0);
        repeat (BIT) @(posedge clk);
        check("single_done_count", done_cnt, 1);
        check("single_data_held", data, 8'h04);
        check("single_no_ferr", ferr_cnt, 0);

        send_frame(8'h06, 1'b1, BIT, 1'b0);
        send_frame(8'h07, 1'b1, BIT, 1'b0);
        repeat (BIT) @(posedge clk);
        check("b2b_done_count", done_cnt, 3);
        check("b2b_spacing", (last_done_cyc - prev_done_cyc >= 1590) && (last_done_cyc - prev_done_cyc <= 1610), 1);
        check("b2b_last_data", data, 8'h07);

        // Stop bit held low only through its sample point so the line idles afterwards.
        send_frame(8'hA5, 1'b0, 100, 1'b0);
        repeat (3 * BIT) @(posedge clk);
        check("ferr_count", ferr_cnt, 1);
        check("ferr_no_done", done_cnt, 3);
        check("ferr_data_kept", data, 8'h07);
        check("ferr_busy_idle", busy, 0);

        rx = 1'b0;
        repeat (40) @(posedge clk);
        rx = 1'b1;
        repeat (100) @(posedge clk);
        check("glitch_busy", busy, 0);
        repeat (2 * BIT) @(posedge clk);
        check("glitch_no_done", done_cnt, 3);
        check("glitch_no_ferr", ferr_cnt, 1);

        partial = 8'h3C;
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = partial[i];
            repeat (BIT) @(posedge clk);
        end
        rx = partial[4];
        repeat (80) @(posedge clk);
        check("midframe_busy", busy, 1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", data, 0);
        rx = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        rst = 1'b0;
        repeat (BIT) @(posedge clk);
        check("rst_no_pulse", done_cnt + ferr_cnt, 4);
        send_frame(8'h3C, 1'b1, BIT, 1'b0);
        repeat (BIT) @(posedge clk);
        check("post_rst_done_count", done_cnt, 4);
        check("post_rst_data", data, 8'h3C);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h04, 1'b1, BIT, 1'b1);
        repeat (BIT) @(posedge clk);
        check("parity_err_count", perr_cnt, 1);
        check("parity_err_no_done", done_cnt, 4);
        check("parity_err_data_kept", data, 8'h3C);
        send_frame(8'h04, 1'b1, BIT, 1'b0);
        repeat (BIT) @(posedge clk);
        check("parity_ok_done", done_cnt, 5);
        check("parity_ok_data", data, 8'h04);
        check("parity_ok_no_perr", perr_cnt, 1);
`endif

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- Serial-to-byte receiver feeding the debug unit's command input.
- Oversamples the host UART line, reassembles 8N1 frames and presents each byte with a one-cycle strobe.
- The debug unit consumes the strobe as its "byte received" event.
- Contains its own oversampling tick generator so it needs no external baud tick.

Parameters:
- BYTE, 8, data bits per frame (LSB first).
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit period; must be even and ≥ 8.

Ports:
- i_clock  input  1  system clock; all logic on the rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_rx  input  1  raw serial line; idle high; asynchronous to i_clock.
- o_data  output  BYTE  last correctly framed byte; held until the next good frame.
- o_rx_done  output  1  one-cycle pulse, asserted in the same cycle o_data updates.
- o_frame_error  output  1  one-cycle pulse when the stop bit samples 0.
- o_busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Interface: one clock (i_clock); reset i_reset is asynchronous and active-high.
- Reset values: o_data=0, o_rx_done=0, o_frame_error=0, o_busy=0, FSM=IDLE, all counters 0, synchroniser flops=1.
- Synchroniser: i_rx passes through a 2-flop synchroniser. Its output rx_s is the only line used internally, giving 2 cycles of input latency.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer-truncated, minimum 1.
  - Free-running counter 0..DIV-1; tick is high for one cycle when the counter = DIV-1, after which it wraps to 0.
  - Runs continuously and is never resynchronised to the frame.
- FSM states IDLE, START, DATA, STOP. s_cnt counts ticks, n_cnt counts bits.
- IDLE: rx_s=0 → START, s_cnt=0. Otherwise stay.
- START:
  - On each tick, s_cnt++.
  - When a tick arrives with s_cnt=OVERSAMPLE/2-1 (mid start bit): if rx_s=0 → DATA with s_cnt=0, n_cnt=0; if rx_s=1 → IDLE (glitch rejected, no pulse).
- DATA:
  - On the tick where s_cnt=OVERSAMPLE-1, sample rx_s into shift-register MSB with a right shift, then set s_cnt=0 and n_cnt++.
  - After sampling bit n_cnt=BYTE-1 → STOP.
- STOP: on the tick where s_cnt=OVERSAMPLE-1, sample rx_s, then go to IDLE next cycle.
  - rx_s=1: o_data ← shift register; o_rx_done=1 for exactly 1 cycle.
  - rx_s=0: o_frame_error=1 for 1 cycle; o_data unchanged.
  - Return to IDLE: the FSM is back in IDLE the cycle after the stop-bit sample, so a new start edge is accepted immediately. A break condition (line held low) therefore produces repeated frame errors, one per frame time.
- o_rx_done and o_frame_error are mutually exclusive and never asserted in consecutive cycles.
- Latency: o_rx_done occurs about (BYTE+1.5)·OVERSAMPLE·DIV cycles (±DIV) after the falling start edge at i_rx, plus 2 synchroniser cycles.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is discarded, no pulse is produced, and the next falling edge starts a fresh frame.
- Tick with no state change: counters only advance on tick. Between ticks all state holds.
- o_busy = (state != IDLE), registered.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, sampled at s_cnt=OVERSAMPLE-1.
  - Even parity over data + parity bit is required.
  - Adds output o_parity_error (1 bit, reset 0), pulsed in the STOP-sample cycle when parity is wrong.
  - On a parity error, o_data is not updated and o_rx_done stays 0.
  - A frame with both a parity error and a frame error pulses both error outputs.
- Undefined: no PARITY state, no o_parity_error port; frame is 8N1.

Decomposition:
- Package uart_pkg: FSM state encoding (localparams ST_IDLE..ST_PARITY, 3 bits wide), default OVERSAMPLE, and the DIV computation as a constant function. Shared with the future uart_tx.
- One sub-module, baud_tick_gen: parameters CLK_FREQ, BAUD, OVERSAMPLE; ports i_clock, i_reset, o_tick. Reused by uart_tx.

Test Plan:
- Common bench setup: CLK_FREQ=50e6, BAUD=312500 (DIV=10, bit time = 160 cycles = 3200 ns), 20 ns clock.
- Reset 100 ns, line idle 1 → all outputs 0, no pulses over 10 bit times.
- Send 8'h04 as 8N1 → one o_rx_done pulse, o_data=8'h04, o_frame_error never high; pulse about 1520 cycles after the start edge (±10).
- Back-to-back 8'h06, 8'h07 with no idle gap → two o_rx_done pulses, 1600 cycles apart (±10); o_data=8'h06 then 8'h07.
- Frame 8'hA5 with stop bit forced 0 → o_frame_error pulse, o_rx_done stays 0, o_data keeps its previous value.
- 40-cycle low glitch on an idle line → returns to IDLE, no pulses, o_busy low again within 100 cycles of the glitch end.
- Assert i_reset during bit 4 of 8'h3C, release, then send 8'h3C → o_busy=0 and no pulse during reset; exactly one o_rx_done with o_data=8'h3C afterwards.
- With UART_RX_PARITY_EN: 8'h04 with wrong parity → o_parity_error pulse, no o_rx_done; correct parity → o_data=8'h04.
